// File: rtl/tt_defs.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and
// the default parameter values used by the top and the settle timer.
package tt_defs;

  // Sweep controller states; the encodings are fixed and visible to other tools.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_t;

  // Default number of inputs of the function under test.
  localparam int DEF_N_IN   = 2;
  // Default number of cycles each minterm is held before sampling.
  localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle delay timer. A load pulse starts a SETTLE-cycle window; expire is
// high during the last cycle of that window (immediately for SETTLE=1).
module tt_settle_timer
  import tt_defs::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  // The counter holds "cycles remaining after this one", so SETTLE-1 is loaded.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every minterm of an N_IN-input combinational
// function, holds each for SETTLE cycles, samples the function output and
// compares the captured table against a reference. All outputs are registers.
module truth_table_sweeper
  import tt_defs::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   s_in,
  output logic [N_IN-1:0]        x_out,
  output logic [N_IN-1:0]        minterm,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   mismatch
);

  localparam int NM = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_M = {N_IN{1'b1}};

  tt_state_t         r_state;
  tt_state_t         w_state_next;
  logic [N_IN-1:0]   r_minterm;
  logic [N_IN-1:0]   w_minterm_next;
  logic [NM-1:0]     r_table;
  logic [NM-1:0]     w_table_next;
  logic [NM-1:0]     w_sampled;
  logic              r_mismatch;
  logic              w_mismatch_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_done;
  logic              w_done_next;
  logic              w_load;
  logic              w_expire;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .expire (w_expire)
  );

  // State and output registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_minterm  <= '0;
      r_table    <= '0;
      r_mismatch <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_minterm  <= w_minterm_next;
      r_table    <= w_table_next;
      r_mismatch <= w_mismatch_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // Next-state and next-output logic; busy/done are derived from the next
  // state so they line up with the state they describe.
  always_comb begin
    w_state_next    = r_state;
    w_minterm_next  = r_minterm;
    w_table_next    = r_table;
    w_mismatch_next = r_mismatch;
    w_load          = 1'b0;
    // Current table with the present s_in written into the active minterm,
    // so the final compare includes the bit captured on the closing edge.
    w_sampled            = r_table;
    w_sampled[r_minterm] = s_in;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next    = ST_SETTLE;
          w_minterm_next  = '0;
          w_table_next    = '0;
          w_mismatch_next = 1'b0;
          w_load          = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_expire) begin
          w_state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_table_next = w_sampled;
        if (r_minterm == LAST_M) begin
          w_state_next    = ST_DONE;
          w_mismatch_next = (w_sampled != expected);
        end else begin
          w_state_next   = ST_SETTLE;
          w_minterm_next = r_minterm + 1'b1;
          w_load         = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);
    w_done_next = (w_state_next == ST_DONE);
  end

  // The function inputs are simply the registered minterm index.
  assign x_out     = r_minterm;
  assign minterm   = r_minterm;
  assign table_out = r_table;
  assign mismatch  = r_mismatch;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
